// File: rtl/full_adder_1bit.sv
// One-bit full adder: the carry-chain cell that adder_2bit uses twice.
// It takes a, b and carry-in ci and produces sum s and carry-out co.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;
  logic g;

  // Propagate and generate terms. A carry leaves the cell when both inputs
  // are set, or when exactly one is set and a carry came in.
  assign p  = a ^ b;
  assign g  = a & b;
  assign s  = p ^ ci;
  assign co = g | (p & ci);

endmodule

// File: rtl/adder_2bit.sv
// 2-bit ripple adder with carry-in. The sum is available combinationally and,
// when REG_OUT=1, also as a copy registered on clk with an asynchronous clear.
module adder_2bit #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic A0,
  input  logic A1,
  input  logic B0,
  input  logic B1,
  input  logic Cin,
  output logic S0,
  output logic S1,
  output logic Cout,
  output logic S0_r,
  output logic S1_r,
  output logic Cout_r
);

  logic c1;

  full_adder_1bit u_bit0 (
    .a  (A0),
    .b  (B0),
    .ci (Cin),
    .s  (S0),
    .co (c1)
  );

  full_adder_1bit u_bit1 (
    .a  (A1),
    .b  (B1),
    .ci (c1),
    .s  (S1),
    .co (Cout)
  );

  // When the registered copy is enabled, rst clears it at once without
  // waiting for a clock edge. The combinational outputs ignore rst.
  generate
    if (REG_OUT) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          S0_r   <= 1'b0;
          S1_r   <= 1'b0;
          Cout_r <= 1'b0;
        end else begin
          S0_r   <= S0;
          S1_r   <= S1;
          Cout_r <= Cout;
        end
      end
    end else begin : g_comb
      assign S0_r   = S0;
      assign S1_r   = S1;
      assign Cout_r = Cout;
    end
  endgenerate

endmodule

// File: tb/tb_adder_2bit.sv
// Directed bench for adder_2bit: exhaustive combinational sweep, hand-checked
// vectors, registered-output latency and asynchronous reset behaviour.
module tb_adder_2bit;

  logic clk = 1'b0;
  logic rst;
  logic A0, A1, B0, B1, Cin;
  logic S0, S1, Cout, S0_r, S1_r, Cout_r;

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];

  adder_2bit #(.REG_OUT(1'b1)) dut (
    .clk    (clk),
    .rst    (rst),
    .A0     (A0),
    .A1     (A1),
    .B0     (B0),
    .B1     (B1),
    .Cin    (Cin),
    .S0     (S0),
    .S1     (S1),
    .Cout   (Cout),
    .S0_r   (S0_r),
    .S1_r   (S1_r),
    .Cout_r (Cout_r)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [2:0] sum_comb();
    return {Cout, S1, S0};
  endfunction

  function automatic logic [2:0] sum_reg();
    return {Cout_r, S1_r, S0_r};
  endfunction

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] a, input logic [1:0] b, input logic ci);
    A0  = a[0];
    A1  = a[1];
    B0  = b[0];
    B1  = b[1];
    Cin = ci;
  endtask

  // Each row holds A, B, Cin and the sum worked out by hand.
  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       ci;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{a: 2'd1, b: 2'd2, ci: 1'b0, exp: 3'd3};
    vecs[1] = '{a: 2'd2, b: 2'd2, ci: 1'b0, exp: 3'd4};
    vecs[2] = '{a: 2'd3, b: 2'd3, ci: 1'b1, exp: 3'd7};
    vecs[3] = '{a: 2'd0, b: 2'd0, ci: 1'b0, exp: 3'd0};
    vecs[4] = '{a: 2'd2, b: 2'd1, ci: 1'b1, exp: 3'd4};
    vecs[5] = '{a: 2'd3, b: 2'd2, ci: 1'b0, exp: 3'd5};

    rst = 1'b1;
    drive(2'd0, 2'd0, 1'b0);
    #2;
    check("reset_reg", sum_reg(), 3'd0);
    check("reset_comb", sum_comb(), 3'd0);

    // Sweep all 32 input combinations, 5 ns apart, while rst is still held.
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      logic [2:0] e;
      v = i[4:0];
      A0  = v[4];
      A1  = v[3];
      B0  = v[2];
      B1  = v[1];
      Cin = v[0];
      e = 3'({A1, A0}) + 3'({B1, B0}) + 3'(Cin);
      #1;
      check("sweep", sum_comb(), e);
      check("sweep_reg_in_rst", sum_reg(), 3'd0);
      #4;
    end

    // Hand-computed combinational vectors.
    drive(2'd1, 2'd2, 1'b0); #1; check("a1_b2_c0", sum_comb(), 3'd3);
    drive(2'd2, 2'd2, 1'b0); #1; check("a2_b2_c0", sum_comb(), 3'd4);
    drive(2'd3, 2'd0, 1'b1); #1; check("ripple_c1", sum_comb(), 3'd4);
    drive(2'd3, 2'd0, 1'b0); #1; check("ripple_c0", sum_comb(), 3'd3);

    // Release reset away from a clock edge.
    @(negedge clk);
    rst = 1'b0;

    // Registered path: one cycle latency, expected values queued.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].ci);
      exp_q.push_back(vecs[i].exp);
      #1;
      check("vec_comb", sum_comb(), vecs[i].exp);
      @(posedge clk);
      #1;
      check("vec_reg", sum_reg(), exp_q.pop_front());
    end

    // A=3, B=3, Cin=1 gives 7. The next edge loads all ones into the register.
    @(negedge clk);
    drive(2'd3, 2'd3, 1'b1);
    @(posedge clk);
    #1;
    check("reg_all_ones", sum_reg(), 3'd7);

    // A Cin toggle with no clock edge changes only the combinational outputs.
    drive(2'd3, 2'd0, 1'b1);
    #1;
    check("toggle_comb_c1", sum_comb(), 3'd4);
    Cin = 1'b0;
    #1;
    check("toggle_comb_c0", sum_comb(), 3'd3);
    check("toggle_reg_held", sum_reg(), 3'd7);

    // Asynchronous reset between edges.
    @(negedge clk);
    drive(2'd3, 2'd3, 1'b1);
    @(posedge clk);
    #2;
    check("pre_rst_reg", sum_reg(), 3'd7);
    rst = 1'b1;
    #1;
    check("async_rst_reg", sum_reg(), 3'd0);
    check("async_rst_comb", sum_comb(), 3'd7);
    @(posedge clk);
    #1;
    check("rst_held_reg", sum_reg(), 3'd0);
    drive(2'd2, 2'd1, 1'b0);
    #1;
    check("rst_comb_follow", sum_comb(), 3'd3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_no_edge", sum_reg(), 3'd0);
    @(posedge clk);
    #1;
    check("release_reload", sum_reg(), 3'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
